// File: rtl/cache_axi_bridge_if.sv
// AXI3/AXI4 master-port bundle between the cache bridge and the memory system.
// Bridge side uses modport master; memory/interconnect side uses modport slave.
interface cache_axi_bridge_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;

   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/cache_axi_bridge.sv
// I/D-cache to AXI bridge: arbitrated reads (dcache priority), one buffered write; CACHE_AXI_BRIDGE_RAW_LINE_EN narrows RAW blocking to the same line.
// Latency: accept in N drives AR or AW/W in N+1; R beats pass straight through to the owning cache in the same cycle.
// Backpressure: AR/AW/W held stable until ready; rready is always 1; dc_wr_rdy low from accept until the cycle after bvalid.
module cache_axi_bridge (
   input  logic         clk,
   input  logic         reset,

   input  logic         ic_rd_req,
   input  logic [2:0]   ic_rd_type,
   input  logic [31:0]  ic_rd_addr,
   output logic         ic_rd_rdy,
   output logic         ic_ret_valid,
   output logic         ic_ret_last,
   output logic [31:0]  ic_ret_data,

   input  logic         dc_rd_req,
   input  logic [2:0]   dc_rd_type,
   input  logic [31:0]  dc_rd_addr,
   output logic         dc_rd_rdy,
   output logic         dc_ret_valid,
   output logic         dc_ret_last,
   output logic [31:0]  dc_ret_data,

   input  logic         dc_wr_req,
   input  logic [2:0]   dc_wr_type,
   input  logic [31:0]  dc_wr_addr,
   input  logic [3:0]   dc_wr_wstrb,
   input  logic [127:0] dc_wr_data,
   output logic         dc_wr_rdy,

   cache_axi_bridge_if.master axi
);

   typedef enum logic {AR_IDLE, AR_SEND} ar_state_e;
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;

   typedef struct packed {
      logic [31:0]  addr;
      logic [1:0]   len;
      logic [2:0]   size;
      logic [3:0]   strb;
      logic [127:0] data;
   } wbuf_t;

   function automatic logic [7:0] burst_len(input logic [2:0] t);
      return (t == 3'b100) ? 8'd3 : 8'd0;
   endfunction

   function automatic logic [2:0] burst_size(input logic [2:0] t);
      return (t == 3'b100) ? 3'd2 : {1'b0, t[1:0]};
   endfunction

   ar_state_e   ar_state;
   logic        ic_out;
   logic        dc_out;
   logic [3:0]  ar_id_q;
   logic [31:0] ar_addr_q;
   logic [7:0]  ar_len_q;
   logic [2:0]  ar_size_q;
   logic        ar_vld_q;

   w_state_e    w_state;
   wbuf_t       wb;
   logic [1:0]  w_cnt;
   logic        aw_vld_q;
   logic        w_vld_q;
   logic        bready_q;
   logic [3:0]  wr_id_q;

   logic        raw_block;
   logic        dc_elig;
   logic        ic_acc;
   logic        r_last;
   logic        wlast_int;
   logic        aw_fin;
   logic        w_fin;

   // The icache never sees a RAW block; only dcache reads can hit the buffered write.
`ifdef CACHE_AXI_BRIDGE_RAW_LINE_EN
   assign raw_block = (w_state != W_IDLE) && (dc_rd_addr[31:4] == wb.addr[31:4]);
`else
   assign raw_block = (w_state != W_IDLE);
`endif

   assign dc_rd_rdy = (ar_state == AR_IDLE) && !dc_out && !raw_block;
   assign dc_elig   = dc_rd_req && dc_rd_rdy;
   assign ic_rd_rdy = (ar_state == AR_IDLE) && !ic_out && !dc_elig;
   assign ic_acc    = ic_rd_req && ic_rd_rdy;
   assign r_last    = axi.rvalid && axi.rlast;

   always_ff @(posedge clk) begin
      if (reset) begin
         ar_state  <= AR_IDLE;
         ic_out    <= 1'b0;
         dc_out    <= 1'b0;
         ar_id_q   <= 4'd0;
         ar_addr_q <= 32'd0;
         ar_len_q  <= 8'd0;
         ar_size_q <= 3'd0;
         ar_vld_q  <= 1'b0;
      end else begin
         // Clear first so a same-cycle accept (stray rlast only) keeps the flag set.
         if (r_last && !axi.rid[0]) ic_out <= 1'b0;
         if (r_last &&  axi.rid[0]) dc_out <= 1'b0;
         case (ar_state)
            AR_IDLE: begin
               if (dc_elig) begin
                  ar_id_q   <= 4'd1;
                  ar_addr_q <= dc_rd_addr;
                  ar_len_q  <= burst_len(dc_rd_type);
                  ar_size_q <= burst_size(dc_rd_type);
                  ar_vld_q  <= 1'b1;
                  dc_out    <= 1'b1;
                  ar_state  <= AR_SEND;
               end else if (ic_acc) begin
                  ar_id_q   <= 4'd0;
                  ar_addr_q <= ic_rd_addr;
                  ar_len_q  <= burst_len(ic_rd_type);
                  ar_size_q <= burst_size(ic_rd_type);
                  ar_vld_q  <= 1'b1;
                  ic_out    <= 1'b1;
                  ar_state  <= AR_SEND;
               end
            end
            AR_SEND: begin
               if (axi.arready) begin
                  ar_vld_q <= 1'b0;
                  ar_state <= AR_IDLE;
               end
            end
         endcase
      end
   end

   assign axi.arid    = ar_id_q;
   assign axi.araddr  = ar_addr_q;
   assign axi.arlen   = ar_len_q;
   assign axi.arsize  = ar_size_q;
   assign axi.arburst = 2'b01;
   assign axi.arvalid = ar_vld_q;
   assign axi.rready  = 1'b1;

   assign ic_ret_valid = axi.rvalid && !axi.rid[0];
   assign ic_ret_last  = ic_ret_valid && axi.rlast;
   assign ic_ret_data  = ic_ret_valid ? axi.rdata : 32'd0;
   assign dc_ret_valid = axi.rvalid && axi.rid[0];
   assign dc_ret_last  = dc_ret_valid && axi.rlast;
   assign dc_ret_data  = dc_ret_valid ? axi.rdata : 32'd0;

   // AW and W retire independently, so either may finish first.
   assign wlast_int = (w_cnt == wb.len);
   assign aw_fin    = !aw_vld_q || axi.awready;
   assign w_fin     = !w_vld_q || (axi.wready && wlast_int);

   always_ff @(posedge clk) begin
      if (reset) begin
         w_state  <= W_IDLE;
         wb       <= '0;
         w_cnt    <= 2'd0;
         aw_vld_q <= 1'b0;
         w_vld_q  <= 1'b0;
         bready_q <= 1'b0;
         wr_id_q  <= 4'd0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (dc_wr_req) begin
                  wb.addr  <= dc_wr_addr;
                  wb.len   <= (dc_wr_type == 3'b100) ? 2'd3 : 2'd0;
                  wb.size  <= burst_size(dc_wr_type);
                  wb.strb  <= (dc_wr_type == 3'b100) ? 4'hf : dc_wr_wstrb;
                  wb.data  <= dc_wr_data;
                  w_cnt    <= 2'd0;
                  aw_vld_q <= 1'b1;
                  w_vld_q  <= 1'b1;
                  wr_id_q  <= 4'd1;
                  w_state  <= W_SEND;
               end
            end
            W_SEND: begin
               if (aw_vld_q && axi.awready) aw_vld_q <= 1'b0;
               if (w_vld_q && axi.wready) begin
                  w_cnt <= w_cnt + 2'd1;
                  if (wlast_int) w_vld_q <= 1'b0;
               end
               if (aw_fin && w_fin) begin
                  bready_q <= 1'b1;
                  w_state  <= W_RESP;
               end
            end
            W_RESP: begin
               if (axi.bvalid) begin
                  bready_q <= 1'b0;
                  w_state  <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   assign dc_wr_rdy   = (w_state == W_IDLE);
   assign axi.awid    = wr_id_q;
   assign axi.awaddr  = wb.addr;
   assign axi.awlen   = {6'd0, wb.len};
   assign axi.awsize  = wb.size;
   assign axi.awburst = 2'b01;
   assign axi.awvalid = aw_vld_q;
   assign axi.wid     = wr_id_q;
   assign axi.wdata   = wb.data[{w_cnt, 5'b0} +: 32];
   assign axi.wstrb   = wb.strb;
   assign axi.wlast   = w_vld_q && wlast_int;
   assign axi.wvalid  = w_vld_q;
   assign axi.bready  = bready_q;

   // Responses are accepted regardless of status; only rid[0] steers data.
   logic unused_axi;
   assign unused_axi = ^{axi.rresp, axi.bresp, axi.bid, axi.rid[3:1]};

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: transaction-level model plus per-cycle compare.
// Expected AR/AW/W traffic is queued at request acceptance; R routing is derived from rid.
module tb_cache_axi_bridge;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic         ic_rd_req, dc_rd_req, dc_wr_req;
   logic [2:0]   ic_rd_type, dc_rd_type, dc_wr_type;
   logic [31:0]  ic_rd_addr, dc_rd_addr, dc_wr_addr;
   logic [3:0]   dc_wr_wstrb;
   logic [127:0] dc_wr_data;
   logic         ic_rd_rdy, dc_rd_rdy, dc_wr_rdy;
   logic         ic_ret_valid, ic_ret_last, dc_ret_valid, dc_ret_last;
   logic [31:0]  ic_ret_data, dc_ret_data;

   logic        arready, awready, wready, rvalid, rlast, bvalid;
   logic [3:0]  rid;
   logic [31:0] rdata;

   cache_axi_bridge_if axi();
   assign axi.arready = arready;
   assign axi.awready = awready;
   assign axi.wready  = wready;
   assign axi.rvalid  = rvalid;
   assign axi.rlast   = rlast;
   assign axi.rid     = rid;
   assign axi.rdata   = rdata;
   assign axi.rresp   = 2'b00;
   assign axi.bvalid  = bvalid;
   assign axi.bid     = 4'd1;
   assign axi.bresp   = 2'b00;

   cache_axi_bridge dut (
      .clk(clk), .reset(reset),
      .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
      .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
      .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
      .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
      .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
      .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
      .axi(axi)
   );

   int errors = 0;
   int checks = 0;
   bit started = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
   } req_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } beat_t;

   function automatic logic [7:0] m_len(input logic [2:0] t);
      return (t == 3'b100) ? 8'd3 : 8'd0;
   endfunction
   function automatic logic [2:0] m_size(input logic [2:0] t);
      return (t == 3'b100) ? 3'd2 : {1'b0, t[1:0]};
   endfunction

   // Transaction-level model of what the master port owes the system.
   bit    m_ar_pend, m_ic_out, m_dc_out, m_w_busy, m_aw_left;
   req_t  m_ar, m_aw;
   beat_t m_beats[$];
   logic [27:0] m_wline;

   always @(negedge clk) begin
      if (started) begin
         bit raw, e_dc, e_ic, e_br, rd_last, wr_acc;
         `ifdef CACHE_AXI_BRIDGE_RAW_LINE_EN
         raw = m_w_busy && (dc_rd_addr[31:4] == m_wline);
         `else
         raw = m_w_busy;
         `endif
         e_dc = !m_ar_pend && !m_dc_out && !raw;
         e_ic = !m_ar_pend && !m_ic_out && !(dc_rd_req && e_dc);
         e_br = m_w_busy && !m_aw_left && (m_beats.size() == 0);

         chk("m_dc_rd_rdy", dc_rd_rdy, e_dc);
         chk("m_ic_rd_rdy", ic_rd_rdy, e_ic);
         chk("m_dc_wr_rdy", dc_wr_rdy, !m_w_busy);
         chk("m_rready", axi.rready, 1'b1);
         chk("m_arvalid", axi.arvalid, m_ar_pend);
         if (m_ar_pend) begin
            chk("m_ar_fields", {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst},
                {m_ar.id, m_ar.addr, m_ar.len, m_ar.size, 2'b01});
         end
         chk("m_awvalid", axi.awvalid, m_aw_left);
         if (m_aw_left) begin
            chk("m_aw_fields", {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst},
                {m_aw.id, m_aw.addr, m_aw.len, m_aw.size, 2'b01});
         end
         chk("m_wvalid", axi.wvalid, m_beats.size() != 0);
         if (m_beats.size() != 0) begin
            chk("m_w_beat", {axi.wid, axi.wdata, axi.wstrb, axi.wlast},
                {4'd1, m_beats[0].data, m_beats[0].strb, m_beats[0].last});
         end
         chk("m_bready", axi.bready, e_br);
         chk("m_ic_ret_valid", ic_ret_valid, rvalid && !rid[0]);
         chk("m_dc_ret_valid", dc_ret_valid, rvalid && rid[0]);
         if (rvalid && !rid[0]) chk("m_ic_ret", {ic_ret_data, ic_ret_last}, {rdata, rlast});
         if (rvalid &&  rid[0]) chk("m_dc_ret", {dc_ret_data, dc_ret_last}, {rdata, rlast});

         if (reset) begin
            m_ar_pend = 0; m_ic_out = 0; m_dc_out = 0;
            m_w_busy = 0; m_aw_left = 0; m_beats.delete();
         end else begin
            rd_last = rvalid && rlast;
            wr_acc  = dc_wr_req && !m_w_busy;
            if (m_ar_pend && arready) m_ar_pend = 0;
            if (rd_last && !rid[0]) m_ic_out = 0;
            if (rd_last &&  rid[0]) m_dc_out = 0;
            if (dc_rd_req && e_dc) begin
               m_ar = '{id: 4'd1, addr: dc_rd_addr, len: m_len(dc_rd_type), size: m_size(dc_rd_type)};
               m_ar_pend = 1; m_dc_out = 1;
            end else if (ic_rd_req && e_ic) begin
               m_ar = '{id: 4'd0, addr: ic_rd_addr, len: m_len(ic_rd_type), size: m_size(ic_rd_type)};
               m_ar_pend = 1; m_ic_out = 1;
            end
            if (e_br && bvalid) m_w_busy = 0;
            if (m_beats.size() != 0 && wready) void'(m_beats.pop_front());
            if (m_aw_left && awready) m_aw_left = 0;
            if (wr_acc) begin
               m_w_busy = 1; m_aw_left = 1;
               m_wline = dc_wr_addr[31:4];
               m_aw = '{id: 4'd1, addr: dc_wr_addr, len: m_len(dc_wr_type), size: m_size(dc_wr_type)};
               if (dc_wr_type == 3'b100) begin
                  for (int k = 0; k < 4; k++)
                     m_beats.push_back('{data: dc_wr_data[32*k +: 32], strb: 4'hf, last: (k == 3)});
               end else begin
                  m_beats.push_back('{data: dc_wr_data[31:0], strb: dc_wr_wstrb, last: 1'b1});
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1;
      ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
      dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
      dc_wr_req = 0; dc_wr_type = 0; dc_wr_addr = 0; dc_wr_wstrb = 0; dc_wr_data = 0;
      arready = 1; awready = 1; wready = 1; bvalid = 0;
      rvalid = 0; rlast = 0; rid = 0; rdata = 0;
      m_ar_pend = 0; m_ic_out = 0; m_dc_out = 0; m_w_busy = 0; m_aw_left = 0;
      m_ar = '0; m_aw = '0; m_wline = '0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      started = 1;

      // Reset state
      @(negedge clk);
      chk("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, ic_ret_valid, dc_ret_valid}, 6'b0);
      chk("rst_rdys", {ic_rd_rdy, dc_rd_rdy, dc_wr_rdy, axi.rready}, 4'b1111);
      chk("rst_addr_id", {axi.araddr, axi.awaddr, axi.arid, axi.awid, axi.wid, axi.wdata}, 0);

      // Single icache line read
      tick();
      ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0100;
      tick();
      ic_rd_req = 0;
      @(negedge clk);
      chk("s1_ar", {axi.arvalid, axi.arid, axi.arlen, axi.arsize, axi.araddr},
          {1'b1, 4'd0, 8'd3, 3'd2, 32'h1C00_0100});
      tick();
      for (int i = 0; i < 4; i++) begin
         rvalid = 1; rid = 4'd0; rdata = 32'hA0 + i; rlast = (i == 3);
         @(negedge clk);
         chk("s1_ic_data", ic_ret_data, 32'hA0 + i);
         chk("s1_ic_last", ic_ret_last, i == 3);
         chk("s1_dc_quiet", dc_ret_valid, 1'b0);
         tick();
      end
      rvalid = 0; rlast = 0;

      // Simultaneous reads, then interleaved returns
      dc_rd_req = 1; dc_rd_type = 3'b100; dc_rd_addr = 32'h0000_2000;
      ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0200;
      @(negedge clk);
      chk("s2_arb_rdy", {dc_rd_rdy, ic_rd_rdy}, 2'b10);
      tick();
      dc_rd_req = 0;
      @(negedge clk);
      chk("s2_dc_ar", {axi.arvalid, axi.arid, axi.araddr}, {1'b1, 4'd1, 32'h0000_2000});
      tick();
      tick();
      ic_rd_req = 0;
      @(negedge clk);
      chk("s2_ic_ar", {axi.arvalid, axi.arid, axi.araddr}, {1'b1, 4'd0, 32'h1C00_0200});
      tick();
      for (int i = 0; i < 8; i++) begin
         rvalid = 1; rid = (i % 2 == 0) ? 4'd1 : 4'd0;
         rdata = ((i % 2 == 0) ? 32'hD000_0000 : 32'hE000_0000) + i; rlast = (i >= 6);
         @(negedge clk);
         chk("s2_route", {dc_ret_valid, ic_ret_valid}, (i % 2 == 0) ? 2'b10 : 2'b01);
         tick();
      end
      rvalid = 0; rlast = 0;

      // Line write-back, AW delayed, W first; RAW-blocked dcache read
      dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h0000_1230;
      dc_wr_data = 128'h88887777_66665555_44443333_22221111;
      tick();
      dc_wr_req = 0; awready = 0;
      dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_123C;
      @(negedge clk);
      chk("s3_beat0", {axi.wvalid, axi.wdata, axi.wlast, axi.awvalid}, {1'b1, 32'h2222_1111, 1'b0, 1'b1});
      chk("s3_rdys", {dc_wr_rdy, dc_rd_rdy}, 2'b00);
      tick();
      tick();
      tick();
      awready = 1;
      @(negedge clk);
      chk("s3_beat3", {axi.wdata, axi.wlast}, {32'h8888_7777, 1'b1});
      tick();
      @(negedge clk);
      chk("s3_resp", {axi.bready, axi.awvalid, axi.wvalid}, 3'b100);
      tick();
      bvalid = 1;
      @(negedge clk);
      chk("s3_wr_rdy_at_b", dc_wr_rdy, 1'b0);
      tick();
      bvalid = 0;
      @(negedge clk);
      chk("s3_after_b", {dc_wr_rdy, dc_rd_rdy}, 2'b11);
      tick();
      dc_rd_req = 0;
      @(negedge clk);
      chk("s3_raw_ar", {axi.arid, axi.araddr, axi.arlen, axi.arsize}, {4'd1, 32'h0000_123C, 8'd0, 3'd2});
      tick();
      rvalid = 1; rid = 4'd1; rdata = 32'h5555_AAAA; rlast = 1;
      @(negedge clk);
      chk("s3_dc_ret", {dc_ret_valid, dc_ret_data}, {1'b1, 32'h5555_AAAA});
      tick();
      rvalid = 0; rlast = 0;

      // Uncached byte store, AW first; read to a different line during the write
      dc_wr_req = 1; dc_wr_type = 3'b000; dc_wr_addr = 32'h0000_3002;
      dc_wr_wstrb = 4'b0100; dc_wr_data = 128'h00CC_0000;
      tick();
      dc_wr_req = 0; wready = 0;
      dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_2000;
      @(negedge clk);
      chk("s4_aw", {axi.awlen, axi.awsize, axi.awaddr}, {8'd0, 3'd0, 32'h0000_3002});
      chk("s4_w", {axi.wstrb, axi.wlast, axi.wdata}, {4'b0100, 1'b1, 32'h00CC_0000});
      `ifdef CACHE_AXI_BRIDGE_RAW_LINE_EN
      chk("s4_other_line", dc_rd_rdy, 1'b1);
      `else
      chk("s4_other_line", dc_rd_rdy, 1'b0);
      `endif
      tick();
      wready = 1;
      tick();
      bvalid = 1;
      tick();
      bvalid = 0;
      tick();
      dc_rd_req = 0;
      tick();
      rvalid = 1; rid = 4'd1; rdata = 32'h1234_5678; rlast = 1;
      tick();
      rvalid = 0; rlast = 0;

      // rlast for ID 0 and a new icache request in the same cycle
      ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h1C00_0010;
      tick();
      ic_rd_req = 0;
      tick();
      rvalid = 1; rid = 4'd0; rdata = 32'h1357_2468; rlast = 1;
      ic_rd_req = 1; ic_rd_addr = 32'h1C00_0020;
      @(negedge clk);
      chk("s5_same_cycle", {ic_rd_rdy, ic_ret_valid}, 2'b01);
      tick();
      rvalid = 0; rlast = 0;
      @(negedge clk);
      chk("s5_next_cycle", ic_rd_rdy, 1'b1);
      tick();
      ic_rd_req = 0;
      @(negedge clk);
      chk("s5_ar", {axi.arid, axi.araddr, axi.arsize}, {4'd0, 32'h1C00_0020, 3'd2});
      tick();
      rvalid = 1; rid = 4'd0; rdata = 32'h2468_1357; rlast = 1;
      tick();
      rvalid = 0; rlast = 0;

      // Reset in the middle of W_SEND
      dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h0000_4000;
      dc_wr_data = 128'hDDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666;
      tick();
      dc_wr_req = 0; awready = 0; wready = 0; reset = 1;
      @(negedge clk);
      chk("s6_pre_reset", {axi.awvalid, axi.wvalid}, 2'b11);
      tick();
      reset = 0; awready = 1; wready = 1;
      @(negedge clk);
      chk("s6_post_reset", {axi.awvalid, axi.wvalid, dc_wr_rdy}, 3'b001);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cache_axi_bridge.md
# cache_axi_bridge

Shared memory-side controller between the instruction cache, the data cache and the single AXI3/AXI4 master port of the core. It accepts each cache's miss-refill read and the data cache's write-back or uncached store, arbitrates reads between the two caches, and drives the AR/R/AW/W/B channels. Each cache may have at most one read outstanding, and at most one write is in flight. Return beats are steered back to the requesting cache by ID.

## Interface
- No parameters: widths are fixed at 32-bit address/data, 128-bit line, 4-bit AXI ID.
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- ic_rd_req / ic_rd_type / ic_rd_addr  in  1/3/32  icache read request; type 3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 line
- ic_rd_rdy  out  1  icache read accepted when ic_rd_req & ic_rd_rdy
- ic_ret_valid / ic_ret_last / ic_ret_data  out  1/1/32  icache return beat, last beat, data
- dc_rd_req / dc_rd_type / dc_rd_addr / dc_rd_rdy  in/in/in/out  1/3/32/1  dcache read request, same encoding as icache
- dc_ret_valid / dc_ret_last / dc_ret_data  out  1/1/32  dcache return beat, last beat, data
- dc_wr_req / dc_wr_type / dc_wr_addr / dc_wr_wstrb / dc_wr_data  in  1/3/32/4/128  dcache write request
- dc_wr_rdy  out  1  write buffer free; independent of dc_wr_req
- arid, araddr, arlen, arsize, arburst, arvalid / arready  out/in  4,32,8,3,2,1 / 1  AXI read address channel
- rid, rdata, rresp, rlast, rvalid / rready  in/out  4,32,2,1,1 / 1  AXI read data channel
- awid, awaddr, awlen, awsize, awburst, awvalid / awready  out/in  4,32,8,3,2,1 / 1  AXI write address channel
- wid, wdata, wstrb, wlast, wvalid / wready  out/in  4,32,4,1,1 / 1  AXI write data channel
- bid, bresp, bvalid / bready  in/out  4,2,1 / 1  AXI write response channel

## Operation
- **IDs.** The icache uses ID 0 and the dcache uses ID 1 for reads. Writes use ID 1 (awid, wid). arburst and awburst are fixed at INCR (2'b01).
- **Size and length.** A line request (type 3'b100) gives len 3 and size 2. Any other type gives len 0 and size = type[1:0].
- **AR FSM: AR_IDLE and AR_SEND.**
  - The ic_outstanding and dc_outstanding flags track which read IDs are in flight.
  - A requester is eligible when its req is high, the FSM is in AR_IDLE, its outstanding flag is 0, and (for the dcache only) it is not RAW-blocked.
  - The dcache has fixed priority. ic_rd_rdy requires that the dcache is not eligible in the same cycle.
  - On accept: latch address, len, size and ID, set the requester's outstanding flag, and move to AR_SEND.
  - AR_SEND holds arvalid with stable fields. On arready the FSM returns to AR_IDLE.
- **R channel.**
  - rready is constantly 1.
  - rid[0] = 0 drives the ic_ret_* outputs; rid[0] = 1 drives the dc_ret_* outputs. Routing is combinational pass-through.
  - The outstanding flag for that ID clears on rvalid & rlast.
  - Beats from the two IDs may interleave. rresp is ignored.
- **W FSM: W_IDLE, W_SEND, W_RESP.**
  - dc_wr_rdy = (state == W_IDLE).
  - On accept: latch addr, len, the 128-bit data and wstrb into the buffer, reset the 2-bit beat counter to 0, and go to W_SEND.
  - wstrb = 4'hf for a line write, dc_wr_wstrb otherwise.
  - W_SEND: awvalid and wvalid are raised together. Each clears independently on its own handshake.
  - wdata = buffer[32*cnt +: 32]. cnt increments on each wvalid & wready.
  - wlast = (cnt == len[1:0]).
  - The FSM goes to W_RESP once both the AW handshake and the W-last handshake have completed.
  - W_RESP: bready = 1. On bvalid the FSM returns to W_IDLE. bresp is ignored.
- **Write-before-AW.** W beats may complete before AW; both orders must be handled.

## Timing
- **Reset values.**
  - All valid outputs, ic_ret_valid/dc_ret_valid, bready and the outstanding flags are 0.
  - rready is 1.
  - ic_rd_rdy, dc_rd_rdy and dc_wr_rdy are 1 in the first cycle after reset.
  - Address, data and ID outputs are 0.
- **Read accept to AR.** A read accepted in cycle N drives arvalid in cycle N+1. A read accept at arready in cycle M makes the FSM ready for another accept in M+1.
- **Write accept to AW/W.** A write accepted in cycle N drives awvalid, wvalid and beat 0 in cycle N+1.
- **Return path.** Return beats reach the cache in the same cycle as rvalid (zero latency).
- **Write completion.** dc_wr_rdy rises in the cycle after bvalid.
- **Simultaneous events.**
  - Both caches eligible: the dcache wins and the icache is accepted no earlier than the next AR_IDLE.
  - An rlast beat for ID X and a new request from cache X in the same cycle: the new request is not accepted that cycle (the flag clears on the edge).
- **Reset mid-transaction.** Reset during any transaction drops all state. In-flight AXI responses after reset are the system's responsibility.

## Configuration
- **CACHE_AXI_BRIDGE_RAW_LINE_EN defined:**
  - A dcache read is RAW-blocked only while the W FSM is not in W_IDLE and dc_rd_addr[31:4] == write buffer addr[31:4].
  - Reads to other lines issue while the write is in flight.
- **Not defined:** a dcache read is RAW-blocked whenever the W FSM is not in W_IDLE.
- In both builds the icache is never RAW-blocked.

## Test plan
- **Single icache line read.** ic_rd_req, type 3'b100, addr 0x1C000100, arready = 1 -> arid 0, arlen 3, arsize 2 at N+1. Four R beats 0xA0..0xA3 -> ic_ret_data matches; ic_ret_last only on beat 3; dc_ret_valid stays 0.
- **Simultaneous reads.** Both caches request line reads in cycle N -> dc_rd_rdy = 1 and ic_rd_rdy = 0 in N; the icache AR (arid 0) follows immediately after the dcache AR (arid 1) handshake.
- **Write-back.** dc_wr line to 0x00001230, data 0x44443333_22221111_...; awready delayed 3 cycles, wready = 1 -> wdata beats 0x..1111 first; wlast on beat 3; dc_wr_rdy low until the cycle after bvalid.
- **Uncached byte store.** type 3'b000, wstrb 4'b0100 -> awlen 0, awsize 0, single beat with wlast = 1, wstrb 4'b0100.
- **RAW block.** A write to line 0x00001230 is pending and a dcache read of 0x0000123C arrives -> dc_rd_rdy stays 0 until W_IDLE. A read of 0x00002000 is accepted immediately only with CACHE_AXI_BRIDGE_RAW_LINE_EN defined.
- **Interleaved returns and reset.** Beats with rid 0 and rid 1 alternate -> each routes to its own cache. Reset asserted during W_SEND -> next cycle awvalid = wvalid = 0 and dc_wr_rdy = 1.
